// File: rtl/posit_add_stream_ctrl.sv
// Streaming valid/ready wrapper around a fixed-latency, non-stalling posit8 adder.
// Optional statistics counters are built when POSIT_ADD_STATS_EN is defined.
module posit_add_stream_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned ADD_LATENCY = 8,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              add_start,
  output logic [DATA_W-1:0] add_in1,
  output logic [DATA_W-1:0] add_in2,
  input  logic [DATA_W-1:0] add_result,
  input  logic              add_inf,
  input  logic              add_zero,
  input  logic              add_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_inf,
  output logic              out_zero,
  output logic              err
`ifdef POSIT_ADD_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_inf,
  output logic [31:0]       stat_zero
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = $clog2(ADD_LATENCY + 1);
  localparam int unsigned SW = ((OW > IW) ? OW : IW) + 1;
  localparam int unsigned EW = TAG_W + 2 + DATA_W;

  typedef enum logic {
    ST_FLUSH,
    ST_RUN
  } state_e;

  state_e                            state_q, state_d;
  logic [IW-1:0]                     cnt_q, cnt_d;
  logic [ADD_LATENCY-1:0]            pipe_v_q, pipe_v_d;
  logic [ADD_LATENCY-1:0][TAG_W-1:0] pipe_tag_q, pipe_tag_d;
  logic [IW-1:0]                     inflight_q, inflight_d;
  logic [OW-1:0]                     occ_q, occ_d;
  logic [AW-1:0]                     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                     rd_ptr_q, rd_ptr_d;
  logic                              err_q, err_d;
  logic [EW-1:0]                     mem_q [FIFO_DEPTH];

  logic                              run;
  logic                              fire;
  logic                              pop;
  logic                              full;
  logic                              push_req;
  logic                              push;
  logic                              overflow;
  logic                              seq_err;
  logic [SW-1:0]                     credit_used;
  logic [ADD_LATENCY:0]              v_ext;
  logic [ADD_LATENCY:0][TAG_W-1:0]   tag_ext;
  logic                              pipe_out_v;
  logic [TAG_W-1:0]                  pipe_out_tag;
  logic [EW-1:0]                     push_entry;
  logic [EW-1:0]                     head;

  assign run         = (state_q == ST_RUN);
  assign credit_used = SW'(occ_q) + SW'(inflight_q);
  assign in_ready    = run && (credit_used < SW'(FIFO_DEPTH));
  assign fire        = in_valid && in_ready;

  assign add_start = fire;
  assign add_in1   = fire ? in_a : '0;
  assign add_in2   = fire ? in_b : '0;

  // Prepending the new stage to the pipe makes its top element the aligned output.
  assign v_ext        = {pipe_v_q, fire};
  assign tag_ext      = {pipe_tag_q, in_tag};
  assign pipe_out_v   = v_ext[ADD_LATENCY];
  assign pipe_out_tag = tag_ext[ADD_LATENCY];
  assign pipe_v_d     = v_ext[ADD_LATENCY-1:0];
  assign pipe_tag_d   = tag_ext[ADD_LATENCY-1:0];

  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (occ_q == OW'(FIFO_DEPTH));
  assign head      = mem_q[rd_ptr_q];

  assign out_result = out_valid ? head[DATA_W-1:0] : '0;
  assign out_zero   = out_valid ? head[DATA_W] : 1'b0;
  assign out_inf    = out_valid ? head[DATA_W+1] : 1'b0;
  assign out_tag    = out_valid ? head[EW-1 -: TAG_W] : '0;
  assign err        = err_q;

  // A result is only accepted when the adder and the tag pipe agree it exists.
  assign seq_err    = run && (add_done != pipe_out_v);
  assign push_req   = run && add_done && pipe_out_v;
  assign push       = push_req && (!full || pop);
  assign overflow   = push_req && full && !pop;
  assign push_entry = {pipe_out_tag, add_inf, add_zero, add_result};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inflight_d = inflight_q + IW'(fire) - IW'(pipe_out_v);
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    err_d      = err_q | seq_err | overflow;

    case (state_q)
      ST_FLUSH: begin
        if (cnt_q == IW'(ADD_LATENCY - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_FLUSH;
    endcase

    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FLUSH;
      cnt_q      <= '0;
      pipe_v_q   <= '0;
      pipe_tag_q <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pipe_v_q   <= pipe_v_d;
      pipe_tag_q <= pipe_tag_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible behind out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

`ifdef POSIT_ADD_STATS_EN
  logic [31:0] st_issued_q, st_issued_d;
  logic [31:0] st_inf_q, st_inf_d;
  logic [31:0] st_zero_q, st_zero_d;

  always_comb begin
    st_issued_d = st_issued_q;
    st_inf_d    = st_inf_q;
    st_zero_d   = st_zero_q;
    if (fire && (st_issued_q != '1)) st_issued_d = st_issued_q + 32'd1;
    if (push && add_inf && (st_inf_q != '1)) st_inf_d = st_inf_q + 32'd1;
    if (push && add_zero && (st_zero_q != '1)) st_zero_d = st_zero_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_issued_q <= '0;
      st_inf_q    <= '0;
      st_zero_q   <= '0;
    end else begin
      st_issued_q <= st_issued_d;
      st_inf_q    <= st_inf_d;
      st_zero_q   <= st_zero_d;
    end
  end

  assign stat_issued = st_issued_q;
  assign stat_inf    = st_inf_q;
  assign stat_zero   = st_zero_q;
`endif

endmodule

// File: tb/tb_posit_add_stream_ctrl.sv
// Scoreboard bench for posit_add_stream_ctrl with a behavioural fixed-latency adder.
module tb_posit_add_stream_ctrl;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned LAT    = 8;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              add_start;
  logic [DATA_W-1:0] add_in1;
  logic [DATA_W-1:0] add_in2;
  logic [DATA_W-1:0] add_result;
  logic              add_inf;
  logic              add_zero;
  logic              add_done;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              out_inf;
  logic              out_zero;
  logic              err;
`ifdef POSIT_ADD_STATS_EN
  logic [31:0]       stat_issued;
  logic [31:0]       stat_inf;
  logic [31:0]       stat_zero;
`endif

  always #5 clk = ~clk;

  posit_add_stream_ctrl #(
    .DATA_W(DATA_W),
    .TAG_W(TAG_W),
    .ADD_LATENCY(LAT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_tag(in_tag),
    .add_start(add_start),
    .add_in1(add_in1),
    .add_in2(add_in2),
    .add_result(add_result),
    .add_inf(add_inf),
    .add_zero(add_zero),
    .add_done(add_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_tag(out_tag),
    .out_inf(out_inf),
    .out_zero(out_zero),
    .err(err)
`ifdef POSIT_ADD_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_inf(stat_inf),
    .stat_zero(stat_zero)
`endif
  );

  // Posit8 es3 sums for the operand pairs this bench uses; NaR for anything else.
  function automatic logic [9:0] radd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    if (a == 8'h80 || b == 8'h80)      r = 8'h80;
    else if (a == 8'h00)               r = b;
    else if (b == 8'h00)               r = a;
    else if (a == (~b + 8'd1))         r = 8'h00;
    else if (a == 8'h40 && b == 8'h40) r = 8'h44;
    else                               r = 8'h80;
    return {(r == 8'h80), (r == 8'h00), r};
  endfunction

  // Adder model: no reset, so ops issued before a reset still complete afterwards.
  logic [LAT-1:0]    st_v = '0;
  logic [DATA_W-1:0] st_a [LAT];
  logic [DATA_W-1:0] st_b [LAT];
  logic              inj_done;
  logic [9:0]        st_r;

  always @(posedge clk) begin
    st_v <= {st_v[LAT-2:0], add_start};
    for (int i = LAT - 1; i > 0; i--) begin
      st_a[i] <= st_a[i-1];
      st_b[i] <= st_b[i-1];
    end
    st_a[0] <= add_in1;
    st_b[0] <= add_in2;
  end

  assign st_r       = radd(st_a[LAT-1][7:0], st_b[LAT-1][7:0]);
  assign add_result = {{(DATA_W-8){1'b0}}, st_r[7:0]};
  assign add_inf    = st_r[9];
  assign add_zero   = st_r[8];
  assign add_done   = st_v[LAT-1] | inj_done;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              inf;
    logic              zero;
    logic [DATA_W-1:0] res;
  } exp_t;

  exp_t sb[$];
  exp_t pop_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic s_ready, s_fire, s_outv, s_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Samples one cycle just after the inputs settle, then advances to the next negedge.
  task automatic step();
    exp_t e;
    logic [9:0] r;
    #1;
    s_ready = in_ready;
    s_fire  = in_valid && in_ready;
    s_outv  = out_valid;
    s_done  = add_done;
    check("add_start", add_start, s_fire);
    check("add_in", {add_in1, add_in2}, s_fire ? {in_a, in_b} : 64'd0);
    if (out_valid && out_ready) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_tag", out_tag, e.tag);
        check("out_result", out_result, e.res);
        check("out_flags", {out_inf, out_zero}, {e.inf, e.zero});
        e.tag = out_tag; e.res = out_result; e.inf = out_inf; e.zero = out_zero;
        pop_log.push_back(e);
      end
    end
    if (s_fire) begin
      r = radd(in_a[7:0], in_b[7:0]);
      e.tag = in_tag; e.inf = r[9]; e.zero = r[8];
      e.res = {{(DATA_W-8){1'b0}}, r[7:0]};
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check("drain_done", sb.size(), 0);
  endtask

  initial begin
    int fl, lat, nf, ns, nout, nerr, ndone;
    rst = 1'b1; in_valid = 1'b1; in_a = 32'h40; in_b = 32'h40; in_tag = 4'd3;
    out_ready = 1'b1; inj_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_add_start", add_start, 0);
    check("rst_add_in1", add_in1, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bus", {out_result, out_tag, out_inf, out_zero}, 0);
    check("rst_err", err, 0);

    // Flush length, then the first op fires as soon as in_ready rises.
    rst = 1'b0;
    fl = 0;
    step();
    while (!s_ready && fl < 50) begin
      fl++;
      step();
    end
    check("flush_len", fl, LAT);
    check("first_fire", s_fire, 1);
    in_valid = 1'b0;
    pop_log.delete();
    lat = 1;
    step();
    while (!s_outv && lat < 50) begin
      lat++;
      step();
    end
    check("latency", lat, LAT + 1);
    check("t1_popped", pop_log.size(), 1);
    if (pop_log.size() == 1) begin
      check("t1_result", pop_log[0].res, 32'h44);
      check("t1_tag", pop_log[0].tag, 3);
      check("t1_flags", {pop_log[0].inf, pop_log[0].zero}, 2'b00);
    end

    // Back-to-back: 1 + -1 then NaR + 1.
    pop_log.delete();
    in_valid = 1'b1; in_a = 32'h40; in_b = 32'hC0; in_tag = 4'd1;
    step();
    check("b2b_fire1", s_fire, 1);
    in_a = 32'h80; in_b = 32'h40; in_tag = 4'd2;
    step();
    check("b2b_fire2", s_fire, 1);
    in_valid = 1'b0;
    drain();
    check("b2b_count", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      check("b2b_r0", {pop_log[0].tag, pop_log[0].inf, pop_log[0].zero, pop_log[0].res},
            {4'd1, 1'b0, 1'b1, 32'h00});
      check("b2b_r1", {pop_log[1].tag, pop_log[1].inf, pop_log[1].zero, pop_log[1].res},
            {4'd2, 1'b1, 1'b0, 32'h80});
    end

    // Credit limit with a stalled consumer.
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h40; in_b = 32'h40; in_tag = 4'd0;
    nf = 0;
    repeat (60) begin
      step();
      if (s_fire) begin
        nf++;
        in_tag++;
      end
    end
    check("fill_fires", nf, DEPTH);
    check("fill_in_ready", in_ready, 0);
    check("fill_out_valid", out_valid, 1);
    check("fill_err", err, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    pop_log.delete();
    drain();
    check("fill_drained", pop_log.size(), DEPTH);
    if (pop_log.size() == DEPTH) check("fill_last_tag", pop_log[DEPTH-1].tag, 15);
    in_valid = 1'b1; in_tag = 4'd5;
    ns = 0;
    step();
    while (!s_fire && ns < 20) begin
      ns++;
      step();
    end
    check("resume_fire", s_fire, 1);
    in_valid = 1'b0;
    drain();

    // Sustained throughput with the consumer always ready.
    in_valid = 1'b1; in_a = 32'h00; in_b = 32'h40; in_tag = 4'd0;
    nf = 0;
    repeat (40) begin
      step();
      if (s_fire) begin
        nf++;
        in_tag++;
      end
    end
    check("throughput", nf, 40);
    in_valid = 1'b0;
    drain();
    check("pre_inj_err", err, 0);

    // Spurious completion with nothing in flight.
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    step();
    check("inj_err", err, 1);
    check("inj_out_valid", out_valid, 0);
    repeat (5) step();
    check("err_sticky", err, 1);

    // Reset with five ops in flight; their completions land during flush.
    in_valid = 1'b1; in_a = 32'h40; in_b = 32'h40;
    nf = 0;
    for (int i = 0; i < 5; i++) begin
      in_tag = 4'(i);
      step();
      if (s_fire) nf++;
    end
    check("rst_inflight_fires", nf, 5);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    sb.delete();
    step();
    step();
    rst = 1'b0;
    nout = 0; nerr = 0; ndone = 0;
    repeat (LAT + 6) begin
      step();
      if (s_outv) nout++;
      if (err) nerr++;
      if (s_done) ndone++;
    end
    check("stale_done_seen", ndone, 5);
    check("stale_out_valid", nout, 0);
    check("stale_err", nerr, 0);

    // Normal service after recovery.
    pop_log.delete();
    in_valid = 1'b1; in_a = 32'h40; in_b = 32'h00; in_tag = 4'd9;
    ns = 0;
    step();
    while (!s_fire && ns < 20) begin
      ns++;
      step();
    end
    check("recover_fire", s_fire, 1);
    in_valid = 1'b0;
    drain();
    check("recover_count", pop_log.size(), 1);
    if (pop_log.size() == 1) check("recover_res", {pop_log[0].tag, pop_log[0].res}, {4'd9, 32'h40});
    check("final_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
